// File: rtl/uart_mbox_pkg.sv
// Shared constants for the UART receive mailbox: register map,
// STATUS/CTRL bit positions, arrow-key codes and their one-hot directions.
package uart_mbox_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIR    = 2'd3;

  localparam int STAT_OVR   = 31;
  localparam int STAT_FULL  = 17;
  localparam int STAT_EMPTY = 16;

  localparam int CTRL_CLR_OVR = 0;
  localparam int CTRL_FLUSH   = 1;

  localparam logic [3:0] DIR_NONE = 4'b0000;
  localparam logic [3:0] DIR_U    = 4'b0001;
  localparam logic [3:0] DIR_D    = 4'b0010;
  localparam logic [3:0] DIR_L    = 4'b0100;
  localparam logic [3:0] DIR_R    = 4'b1000;

  localparam logic [7:0] KEY_U = 8'h55;
  localparam logic [7:0] KEY_D = 8'h44;
  localparam logic [7:0] KEY_L = 8'h4C;
  localparam logic [7:0] KEY_R = 8'h52;

  function automatic logic [3:0] key_to_dir(input logic [7:0] k);
    logic [3:0] d;
    d = DIR_NONE;
    case (k)
      KEY_U:   d = DIR_U;
      KEY_D:   d = DIR_D;
      KEY_L:   d = DIR_L;
      KEY_R:   d = DIR_R;
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_mailbox_fifo.sv
// Circular word FIFO for the receive mailbox: push/pop/flush,
// head word, fill count and full/empty flags.
module mbox_fifo
  import uart_mbox_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              cpu_clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_pop;
  logic              do_push;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = mem[rd_ptr];

  // a full FIFO still takes a push when a pop frees the slot
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge cpu_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_mailbox.sv
// UART receive mailbox: FIFO-backed DATA/STATUS/CTRL/DIR registers,
// sticky overrun, threshold irq. Optional arrow-key decode: KEY_DECODE_EN.
module uart_rx_mailbox
  import uart_mbox_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int THRESH = 1
) (
  input  logic              cpu_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irq,
  output logic [3:0]        dir
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              pop_ok;
  logic              ctrl_wr;
  logic              flush;
  logic              clr_ovr;
  logic              push_ok;
  logic              drop;
  logic              overrun;
  logic              unused_wdata;

  assign unused_wdata = ^wdata[31:2];

  assign pop_ok  = sel & ~we & (addr == REG_DATA) & ~empty;
  assign ctrl_wr = sel & we & (addr == REG_CTRL);
  assign flush   = ctrl_wr & wdata[CTRL_FLUSH];
  assign clr_ovr = ctrl_wr & wdata[CTRL_CLR_OVR];
  assign push_ok = in_valid & ~flush & (~full | pop_ok);
  assign drop    = in_valid & ~flush & full & ~pop_ok;

  mbox_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .cpu_clk (cpu_clk),
    .rst     (rst),
    .push    (in_valid),
    .pop     (pop_ok),
    .flush   (flush),
    .wdata   (in_data),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst)          overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

  assign irq = (count >= CNT_W'(THRESH));

`ifdef KEY_DECODE_EN
  logic [3:0] dir_q;

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst)          dir_q <= DIR_NONE;
    else if (push_ok) dir_q <= key_to_dir(in_data[7:0]);
  end

  assign dir = dir_q;
`else
  assign dir = DIR_NONE;
`endif

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (addr == REG_DATA): begin
        if (!empty) rdata = 32'(head);
      end
      (addr == REG_STATUS): begin
        rdata[STAT_OVR]   = overrun;
        rdata[STAT_FULL]  = full;
        rdata[STAT_EMPTY] = empty;
        rdata[CNT_W-1:0]  = count;
      end
      (addr == REG_DIR): begin
        rdata = {28'b0, dir};
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_mailbox.sv
// Directed self-checking bench for uart_rx_mailbox
// (DEPTH=16, THRESH=4); dir expectations follow KEY_DECODE_EN.
module tb_uart_rx_mailbox;

  logic        cpu_clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [3:0]  dir;

  int total;
  int bad;

  localparam logic [31:0] ST_EMPTY = 32'h0001_0000;
  localparam logic [31:0] ST_FULL  = 32'h0002_0010;
  localparam logic [31:0] ST_OVR   = 32'h8000_0000;

  uart_rx_mailbox #(
    .DATA_W (8),
    .DEPTH  (16),
    .THRESH (4)
  ) dut (
    .cpu_clk  (cpu_clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq),
    .dir      (dir)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic push(input logic [7:0] b);
    @(negedge cpu_clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge cpu_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [1:0] a, output logic [31:0] v);
    @(negedge cpu_clk);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    #1;
    v = rdata;
    @(posedge cpu_clk);
    #1;
    sel = 1'b0;
  endtask

  task automatic ctrl_store(input logic [31:0] v);
    @(negedge cpu_clk);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = 2'd2;
    wdata = v;
    @(posedge cpu_clk);
    #1;
    sel   = 1'b0;
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b1;
    #12;
    rst = 1'b0;
    load(2'd1, v);
    total++;
    if (v !== ST_EMPTY) begin
      bad++;
      $display("FAIL reset_status got=%h exp=%h", v, ST_EMPTY);
    end
    total++;
    if (irq !== 1'b0 || dir !== 4'b0000) begin
      bad++;
      $display("FAIL reset_irq_dir got=%b/%b exp=0/0000", irq, dir);
    end
  endtask

  task automatic test_basic;
    logic [31:0] v;
    logic [7:0]  exp [3];
    exp[0] = 8'h41;
    exp[1] = 8'h42;
    exp[2] = 8'h43;
    for (int i = 0; i < 3; i++) push(exp[i]);
    load(2'd1, v);
    total++;
    if (v !== 32'h0000_0003) begin
      bad++;
      $display("FAIL basic_status got=%h exp=00000003", v);
    end
    for (int i = 0; i < 3; i++) begin
      load(2'd0, v);
      total++;
      if (v !== {24'b0, exp[i]}) begin
        bad++;
        $display("FAIL basic_data%0d got=%h exp=%h", i, v, exp[i]);
      end
    end
    load(2'd1, v);
    total++;
    if (v !== ST_EMPTY) begin
      bad++;
      $display("FAIL basic_empty got=%h exp=%h", v, ST_EMPTY);
    end
  endtask

  task automatic test_overrun;
    logic [31:0] v;
    for (int i = 0; i < 17; i++) push(8'(i));
    load(2'd1, v);
    total++;
    if (v !== (ST_OVR | ST_FULL)) begin
      bad++;
      $display("FAIL ovr_status got=%h exp=%h", v, ST_OVR | ST_FULL);
    end
    for (int i = 0; i < 16; i++) begin
      load(2'd0, v);
      total++;
      if (v !== 32'(i)) begin
        bad++;
        $display("FAIL ovr_drain%0d got=%h exp=%h", i, v, 32'(i));
      end
    end
    load(2'd0, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL ovr_empty_load got=%h exp=0", v);
    end
    load(2'd1, v);
    total++;
    if (v !== (ST_OVR | ST_EMPTY)) begin
      bad++;
      $display("FAIL ovr_sticky got=%h exp=%h", v, ST_OVR | ST_EMPTY);
    end
    ctrl_store(32'h1);
    load(2'd1, v);
    total++;
    if (v !== ST_EMPTY) begin
      bad++;
      $display("FAIL ovr_clear got=%h exp=%h", v, ST_EMPTY);
    end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] v;
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    @(negedge cpu_clk);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    sel      = 1'b1;
    we       = 1'b0;
    addr     = 2'd0;
    #1;
    v = rdata;
    @(posedge cpu_clk);
    #1;
    in_valid = 1'b0;
    sel      = 1'b0;
    total++;
    if (v !== 32'h20) begin
      bad++;
      $display("FAIL fullpp_head got=%h exp=00000020", v);
    end
    load(2'd1, v);
    total++;
    if (v !== ST_FULL) begin
      bad++;
      $display("FAIL fullpp_status got=%h exp=%h", v, ST_FULL);
    end
    for (int i = 1; i < 17; i++) begin
      load(2'd0, v);
      total++;
      if (v !== ((i == 16) ? 32'hAA : 32'h20 + 32'(i))) begin
        bad++;
        $display("FAIL fullpp_drain%0d got=%h", i, v);
      end
    end
  endtask

  task automatic test_empty_push_pop;
    logic [31:0] v;
    @(negedge cpu_clk);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    sel      = 1'b1;
    we       = 1'b0;
    addr     = 2'd0;
    #1;
    v = rdata;
    @(posedge cpu_clk);
    #1;
    in_valid = 1'b0;
    sel      = 1'b0;
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL emptypp_data got=%h exp=0", v);
    end
    load(2'd1, v);
    total++;
    if (v !== 32'h1) begin
      bad++;
      $display("FAIL emptypp_status got=%h exp=00000001", v);
    end
    load(2'd0, v);
    total++;
    if (v !== 32'h5A) begin
      bad++;
      $display("FAIL emptypp_word got=%h exp=0000005a", v);
    end
  endtask

  task automatic test_irq;
    logic [31:0] v;
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_cnt0 got=%b exp=0", irq);
    end
    for (int i = 1; i <= 4; i++) begin
      push(8'h30 + 8'(i));
      total++;
      if (irq !== (i >= 4)) begin
        bad++;
        $display("FAIL irq_cnt%0d got=%b exp=%b", i, irq, i >= 4);
      end
    end
    ctrl_store(32'h2);
    load(2'd1, v);
    total++;
    if (v !== ST_EMPTY || irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_flush got=%h/%b exp=%h/0", v, irq, ST_EMPTY);
    end
  endtask

  task automatic test_clear_race;
    logic [31:0] v;
    for (int i = 0; i < 17; i++) push(8'h60);
    @(negedge cpu_clk);
    in_valid = 1'b1;
    in_data  = 8'h61;
    sel      = 1'b1;
    we       = 1'b1;
    addr     = 2'd2;
    wdata    = 32'h1;
    @(posedge cpu_clk);
    #1;
    in_valid = 1'b0;
    sel      = 1'b0;
    we       = 1'b0;
    wdata    = '0;
    load(2'd1, v);
    total++;
    if (v !== (ST_OVR | ST_FULL)) begin
      bad++;
      $display("FAIL race_set_wins got=%h exp=%h", v, ST_OVR | ST_FULL);
    end
    ctrl_store(32'h3);
    load(2'd1, v);
    total++;
    if (v !== ST_EMPTY) begin
      bad++;
      $display("FAIL race_flush_clear got=%h exp=%h", v, ST_EMPTY);
    end
  endtask

  task automatic test_flush_push;
    logic [31:0] v;
    push(8'h11);
    push(8'h12);
    @(negedge cpu_clk);
    in_valid = 1'b1;
    in_data  = 8'h13;
    sel      = 1'b1;
    we       = 1'b1;
    addr     = 2'd2;
    wdata    = 32'h2;
    @(posedge cpu_clk);
    #1;
    in_valid = 1'b0;
    sel      = 1'b0;
    we       = 1'b0;
    wdata    = '0;
    load(2'd1, v);
    total++;
    if (v !== ST_EMPTY) begin
      bad++;
      $display("FAIL flush_push got=%h exp=%h", v, ST_EMPTY);
    end
  endtask

  task automatic test_dir;
    logic [31:0] v;
    logic [7:0]  keys [5];
    logic [3:0]  exp  [5];
    keys[0] = 8'h55; exp[0] = 4'b0001;
    keys[1] = 8'h52; exp[1] = 4'b1000;
    keys[2] = 8'h7A; exp[2] = 4'b0000;
    keys[3] = 8'h44; exp[3] = 4'b0010;
    keys[4] = 8'h4C; exp[4] = 4'b0100;
`ifndef KEY_DECODE_EN
    for (int i = 0; i < 5; i++) exp[i] = 4'b0000;
`endif
    for (int i = 0; i < 5; i++) begin
      push(keys[i]);
      total++;
      if (dir !== exp[i]) begin
        bad++;
        $display("FAIL dir_key%0d got=%b exp=%b", i, dir, exp[i]);
      end
    end
    load(2'd3, v);
    total++;
    if (v !== {28'b0, exp[4]}) begin
      bad++;
      $display("FAIL dir_reg got=%h exp=%h", v, {28'b0, exp[4]});
    end
    ctrl_store(32'h2);
    for (int i = 0; i < 16; i++) push(8'h55);
    push(8'h52);
    total++;
`ifdef KEY_DECODE_EN
    if (dir !== 4'b0001) begin
`else
    if (dir !== 4'b0000) begin
`endif
      bad++;
      $display("FAIL dir_dropped got=%b", dir);
    end
    ctrl_store(32'h3);
  endtask

  task automatic test_async_reset;
    logic [31:0] v;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    @(negedge cpu_clk);
    in_valid = 1'b1;
    in_data  = 8'h99;
    sel      = 1'b1;
    we       = 1'b0;
    addr     = 2'd1;
    #2;
    rst = 1'b1;
    #1;
    v = rdata;
    total++;
    if (v !== ST_EMPTY) begin
      bad++;
      $display("FAIL arst_immediate got=%h exp=%h", v, ST_EMPTY);
    end
    @(posedge cpu_clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    sel      = 1'b0;
    load(2'd1, v);
    total++;
    if (v !== ST_EMPTY || dir !== 4'b0000) begin
      bad++;
      $display("FAIL arst_lost_push got=%h/%b exp=%h/0000", v, dir, ST_EMPTY);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    sel      = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;
    test_reset;
    test_basic;
    test_overrun;
    test_full_push_pop;
    test_empty_push_pop;
    test_irq;
    test_clear_race;
    test_flush_push;
    test_dir;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
